mul_product_accumulator: RTL and testbench
==========================================

Name: mul_product_accumulator

Overview:
Downstream stage of the registered N-bit multiplier. Consumes one 2N-bit unsigned product per handshake and accumulates a frame of `len` products into a wide sum. It emits the frame sum, the term count and a sticky overflow flag on a valid/ready output. This turns the multiplier into a multiply-accumulate datapath for dot-product style workloads.

Parameters:
N, 32, multiplier operand width; the product input is 2N bits.
ACC_W, 2*N+8, accumulator and output sum width; must be >= 2N (elaboration error otherwise).
CNT_W, 8, width of the frame length and term counter.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset.
product  input  2N  unsigned product from the multiplier output registers.
in_valid  input  1  product is valid this cycle.
in_ready  output  1  block accepts a product this cycle.
len  input  CNT_W  frame length; sampled on the first term of each frame; 0 is treated as 1.
flush  input  1  synchronous abort of the current frame and any pending result.
out_sum  output  ACC_W  accumulated frame sum.
out_terms  output  CNT_W  number of terms in the emitted frame.
out_ovf  output  1  a carry out of ACC_W occurred in this frame.
out_valid  output  1  result valid.
out_ready  input  1  downstream accepts the result.

Behaviour:
- Clocking and reset: single clock clk. reset is asynchronous, active-low.
- While reset is low: state=ACCUM, acc=0, cnt=0, len_q=0, ovf=0, out_sum=0, out_terms=0, out_ovf=0, out_valid=0, in_ready=0. in_ready is forced low during reset.
- States: ACCUM (taking terms) and HOLD (result pending).
- in_ready = (state==ACCUM) and reset deasserted. in_fire = in_valid & in_ready. out_fire = out_valid & out_ready.
- ACCUM, on in_fire with cnt==0: acc <= zero-extended product; ovf <= 0; len_q <= (len==0 ? 1 : len).
- ACCUM, on in_fire with cnt>0: {carry, acc} <= acc + zero-extend(product); ovf <= ovf | carry. The sum wraps modulo 2^ACC_W.
- Last term: the term where cnt+1 equals the effective length (len_q, or the freshly sampled length when cnt==0). On that fire, in the same edge:
  - out_sum <= new acc value; out_terms <= cnt+1; out_ovf <= new ovf value; out_valid <= 1; state <= HOLD; cnt <= 0.
  - Otherwise cnt <= cnt+1.
- Latency: out_valid rises one cycle after the last in_fire.
- HOLD: in_ready=0. out_sum, out_terms and out_ovf are held stable while out_ready=0. On out_fire: out_valid <= 0, state <= ACCUM. in_ready is high the next cycle, so there is one bubble per frame.
- No input in ACCUM: all state holds. in_valid is ignored while in_ready=0.
- flush=1 (any state) has priority over in_fire and out_fire: acc=0, cnt=0, ovf=0, out_valid <= 0, state <= ACCUM. The product presented in that cycle is dropped.
- Asserting reset mid-frame or mid-HOLD discards everything immediately; no partial result is emitted.

Decomposition:
- Shared package mul_pkg: default N/ACC_W/CNT_W constants and the state enum (ST_ACCUM, ST_HOLD).
- One natural sub-module: mul_acc_datapath. It holds the ACC_W adder with zero-extension and carry out, plus the acc/ovf registers with load/accumulate/clear controls.
- The controller (FSM, counter, handshake, output registers) stays in the top.

Test Plan:
1. Reset: hold reset=0 for 3 cycles mid-frame, then release -> out_valid=0, out_sum=0, out_ovf=0; in_ready=0 during reset, 1 the first cycle after release.
2. Basic frame (N=32, ACC_W=72): len=3, products 5, 7, 11 on consecutive cycles -> one cycle after the third fire, out_valid=1, out_sum=23, out_terms=3, out_ovf=0, in_ready=0.
3. Backpressure: after test 2, hold out_ready=0 for 5 cycles while in_valid=1 with product 99 -> outputs stay at 23/3/0 and no term is accepted. Set out_ready=1 -> out_valid=0 and in_ready=1 on the next cycle, and 99 becomes term 1 of the next frame.
4. Overflow (ACC_W=64 override): len=2, products 0xFFFF_FFFF_FFFF_FFFF then 2 -> out_sum=1, out_ovf=1. The next frame, len=1 with product 3 -> out_sum=3, out_ovf=0.
5. Zero length: len=0, product 42 -> out_valid one cycle later, out_sum=42, out_terms=1.
6. Flush: len=4, terms 10 and 20, then flush=1 with in_valid=1 and product 500; then terms 1, 2, 3, 4 -> a single result with out_sum=10 and out_terms=4; 500 is never accumulated.

Source files
------------

// File: rtl/mul_pkg.sv
// mul_pkg: shared widths and controller state encoding for the multiply-accumulate stage
package mul_pkg;
   localparam int N_DEF     = 32;
   localparam int ACC_W_DEF = 2 * N_DEF + 8;
   localparam int CNT_W_DEF = 8;
   typedef enum logic {ST_ACCUM, ST_HOLD} state_t;
endpackage

// File: rtl/mul_product_accumulator_if.sv
// mul_product_accumulator_if: product input handshake, frame control and result handshake
interface mul_product_accumulator_if
   import mul_pkg::*;
#(
   parameter int N     = N_DEF,
   parameter int ACC_W = 2 * N + 8,
   parameter int CNT_W = CNT_W_DEF
);
   logic [2*N-1:0]   product;
   logic             in_valid;
   logic             in_ready;
   logic [CNT_W-1:0] len;
   logic             flush;
   logic [ACC_W-1:0] out_sum;
   logic [CNT_W-1:0] out_terms;
   logic             out_ovf;
   logic             out_valid;
   logic             out_ready;
   modport master (output product, in_valid, len, flush, out_ready,
                   input  in_ready, out_sum, out_terms, out_ovf, out_valid);
   modport slave  (input  product, in_valid, len, flush, out_ready,
                   output in_ready, out_sum, out_terms, out_ovf, out_valid);
endinterface

// File: rtl/mul_acc_datapath.sv
// mul_acc_datapath: wide accumulator with zero-extended add, carry-out and sticky overflow
module mul_acc_datapath
   import mul_pkg::*;
#(
   parameter int N     = N_DEF,
   parameter int ACC_W = 2 * N + 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2*N-1:0]   product,
   input  logic             load,
   input  logic             accum,
   input  logic             clear,
   output logic [ACC_W-1:0] acc_nxt,
   output logic             ovf_nxt
);
   logic [ACC_W-1:0] acc;
   logic             ovf;
   logic [ACC_W:0]   sum;
   assign sum     = {1'b0, acc} + (ACC_W+1)'(product);
   assign acc_nxt = load ? ACC_W'(product) : sum[ACC_W-1:0];
   assign ovf_nxt = !load && (ovf || sum[ACC_W]);
   // clear wins; otherwise a first term loads and later terms accumulate
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc <= '0;
         ovf <= 1'b0;
      end else if (clear) begin
         acc <= '0;
         ovf <= 1'b0;
      end else if (load || accum) begin
         acc <= acc_nxt;
         ovf <= ovf_nxt;
      end
   end
endmodule

// File: rtl/mul_product_accumulator.sv
// mul_product_accumulator: sums frames of len products and emits sum/terms/overflow on valid/ready
module mul_product_accumulator
   import mul_pkg::*;
#(
   parameter int N     = N_DEF,
   parameter int ACC_W = 2 * N + 8,
   parameter int CNT_W = CNT_W_DEF
) (
   input logic clk,
   input logic reset,
   mul_product_accumulator_if.slave bus
);
   if (ACC_W < 2 * N) begin : g_width_check
      $error("ACC_W must be at least 2*N");
   end
   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, len_q, eff_len;
   logic             fire, last, out_fire;
   logic [ACC_W-1:0] acc_nxt;
   logic             ovf_nxt;
   assign bus.in_ready  = reset && state == ST_ACCUM;
   assign bus.out_valid = state == ST_HOLD;
   assign fire     = bus.in_valid && bus.in_ready && !bus.flush;
   assign out_fire = bus.out_valid && bus.out_ready;
   assign eff_len  = cnt != '0 ? len_q : bus.len != '0 ? bus.len : CNT_W'(1);
   assign last     = ({1'b0, cnt} + 1'b1) == {1'b0, eff_len};
   mul_acc_datapath #(.N(N), .ACC_W(ACC_W)) u_dp (
      .clk     (clk),
      .reset   (reset),
      .product (bus.product),
      .load    (fire && cnt == '0),
      .accum   (fire && cnt != '0),
      .clear   (bus.flush),
      .acc_nxt (acc_nxt),
      .ovf_nxt (ovf_nxt)
   );
   // state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_ACCUM;
      else        state <= state_nxt;
   end
   // flush aborts; last term enters HOLD; accepted result returns to ACCUM
   always_comb begin
      state_nxt = bus.flush ? ST_ACCUM : (fire && last) ? ST_HOLD : out_fire ? ST_ACCUM : state;
   end
   // term counter, frame length capture and result registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt           <= '0;
         len_q         <= '0;
         bus.out_sum   <= '0;
         bus.out_terms <= '0;
         bus.out_ovf   <= 1'b0;
      end else begin
         if (bus.flush) cnt <= '0;
         else if (fire) cnt <= last ? '0 : cnt + 1'b1;
         if (fire && cnt == '0) len_q <= eff_len;
         if (fire && last) begin
            bus.out_sum   <= acc_nxt;
            bus.out_terms <= cnt + 1'b1;
            bus.out_ovf   <= ovf_nxt;
         end
      end
   end
endmodule

// File: tb/tb_mul_product_accumulator.sv
// tb_mul_product_accumulator: directed scenarios plus randomized frames against a frame-level model
module tb_mul_product_accumulator;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   failures = 0;
   mul_product_accumulator_if #(.N(32), .ACC_W(72), .CNT_W(8)) ifc ();
   mul_product_accumulator_if #(.N(32), .ACC_W(64), .CNT_W(8)) ifc64 ();
   mul_product_accumulator #(.N(32), .ACC_W(72), .CNT_W(8)) dut (.clk(clk), .reset(reset), .bus(ifc));
   mul_product_accumulator #(.N(32), .ACC_W(64), .CNT_W(8)) dut64 (.clk(clk), .reset(reset), .bus(ifc64));
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drv(input logic v, input logic [63:0] p, input logic [7:0] l);
      ifc.in_valid = v;
      ifc.product  = p;
      ifc.len      = l;
   endtask

   task automatic drv64(input logic v, input logic [63:0] p, input logic [7:0] l);
      ifc64.in_valid = v;
      ifc64.product  = p;
      ifc64.len      = l;
   endtask

   task automatic chk_res(input string tag, input logic [127:0] sum, input logic [127:0] terms, input logic ovf);
      chk({tag, ".valid"}, ifc.out_valid, 1);
      chk({tag, ".sum"}, ifc.out_sum, sum);
      chk({tag, ".terms"}, ifc.out_terms, terms);
      chk({tag, ".ovf"}, ifc.out_ovf, ovf);
   endtask

   logic [127:0] exact, e_sum;
   int           n, flen, e_terms;
   bit           pend;
   logic         v, f, r;
   logic [63:0]  p;
   logic [7:0]   l;

   initial begin
      drv(0, 0, 0);
      drv64(0, 0, 0);
      ifc.flush = 0; ifc.out_ready = 0;
      ifc64.flush = 0; ifc64.out_ready = 0;
      // reset, including a reset landing in the middle of a frame
      repeat (2) step();
      chk("rst.in_ready", ifc.in_ready, 0);
      reset = 1'b1;
      drv(1, 5, 3);
      step();
      drv(0, 0, 3);
      #2 reset = 1'b0;
      #1 chk("rst_mid.in_ready", ifc.in_ready, 0);
      repeat (3) step();
      chk("rst_hold.in_ready", ifc.in_ready, 0);
      chk("rst_hold.valid", ifc.out_valid, 0);
      reset = 1'b1;
      #1;
      chk("rel.in_ready", ifc.in_ready, 1);
      chk("rel.valid", ifc.out_valid, 0);
      chk("rel.sum", ifc.out_sum, 0);
      chk("rel.ovf", ifc.out_ovf, 0);
      // basic frame 5+7+11
      drv(1, 5, 3); step();
      drv(1, 7, 3); step();
      drv(1, 11, 3); step();
      drv(1, 99, 3);
      chk_res("basic", 23, 3, 0);
      chk("basic.in_ready", ifc.in_ready, 0);
      // backpressure: result held, 99 not taken
      for (int i = 0; i < 5; i++) begin
         step();
         chk_res("bp", 23, 3, 0);
         chk("bp.in_ready", ifc.in_ready, 0);
      end
      ifc.out_ready = 1;
      drv(1, 99, 2);
      step();
      chk("bp_rel.valid", ifc.out_valid, 0);
      chk("bp_rel.in_ready", ifc.in_ready, 1);
      step();
      drv(1, 1, 2);
      step();
      drv(0, 0, 0);
      chk_res("after_bp", 100, 2, 0);
      step();
      chk("after_bp.drain", ifc.out_valid, 0);
      // zero length behaves as one
      ifc.out_ready = 0;
      drv(1, 42, 0); step();
      drv(0, 0, 0);
      chk_res("len0", 42, 1, 0);
      ifc.out_ready = 1; step();
      // flush drops partial frame and the flushed product
      ifc.out_ready = 0;
      drv(1, 10, 4); step();
      drv(1, 20, 4); step();
      drv(1, 500, 4); ifc.flush = 1; step();
      ifc.flush = 0;
      chk("flush.in_ready", ifc.in_ready, 1);
      for (int i = 1; i <= 4; i++) begin
         drv(1, 64'(i), 4);
         step();
      end
      drv(0, 0, 0);
      chk_res("flush", 10, 4, 0);
      ifc.out_ready = 1; step();
      chk("flush.drain", ifc.out_valid, 0);
      // overflow on the 64-bit accumulator, cleared by the next frame
      ifc64.out_ready = 0;
      drv64(1, 64'hFFFF_FFFF_FFFF_FFFF, 2); step();
      drv64(1, 2, 2); step();
      drv64(0, 0, 0);
      chk("ovf.valid", ifc64.out_valid, 1);
      chk("ovf.sum", ifc64.out_sum, 1);
      chk("ovf.flag", ifc64.out_ovf, 1);
      chk("ovf.terms", ifc64.out_terms, 2);
      ifc64.out_ready = 1; step();
      drv64(1, 3, 1); step();
      drv64(0, 0, 0);
      chk("ovf_next.sum", ifc64.out_sum, 3);
      chk("ovf_next.flag", ifc64.out_ovf, 0);
      step();
      // randomized frames on both widths against a frame-level model
      ifc.flush = 1; ifc64.flush = 1; step();
      ifc.flush = 0; ifc64.flush = 0;
      n = 0; exact = 0; pend = 0; flen = 1; e_sum = 0; e_terms = 0;
      for (int c = 0; c < 800; c++) begin
         v = $urandom_range(0, 3) != 0;
         p = $urandom_range(0, 2) == 0 ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
         l = 8'($urandom_range(0, 6));
         f = $urandom_range(0, 40) == 0;
         r = $urandom_range(0, 2) != 0;
         drv(v, p, l); drv64(v, p, l);
         ifc.flush = f; ifc64.flush = f;
         ifc.out_ready = r; ifc64.out_ready = r;
         chk("rnd.in_ready", ifc.in_ready, !pend);
         chk("rnd.in_ready64", ifc64.in_ready, !pend);
         if (f) begin
            n = 0; exact = 0; pend = 0;
         end else if (!pend && v) begin
            if (n == 0) begin
               flen = l == 0 ? 1 : int'(l);
               exact = 0;
            end
            exact = exact + 128'(p);
            n++;
            if (n == flen) begin
               pend = 1; e_sum = exact; e_terms = n; n = 0;
            end
         end else if (pend && r) pend = 0;
         step();
         chk("rnd.valid", ifc.out_valid, pend);
         chk("rnd.valid64", ifc64.out_valid, pend);
         if (pend) begin
            chk("rnd.sum", ifc.out_sum, e_sum[71:0]);
            chk("rnd.terms", ifc.out_terms, 128'(e_terms));
            chk("rnd.ovf", ifc.out_ovf, |e_sum[127:72]);
            chk("rnd.sum64", ifc64.out_sum, e_sum[63:0]);
            chk("rnd.terms64", ifc64.out_terms, 128'(e_terms));
            chk("rnd.ovf64", ifc64.out_ovf, |e_sum[127:64]);
         end
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
